nmr_tick_sched: RTL and testbench

- Programmable timing-clock controller.
- Samples the 5 MHz reference clock, counts its rising edges, and produces a programmable square wave plus a one-cycle tick per period.
- Sequences the pulse-timing clock: configure, start, optional burst length, orderly stop, done report.
- Sits between the host register block and the NMR pulse-sequence logic; the default configuration reproduces the 10 kHz timing clock.

---
 rtl/nmr_tick_sched.sv | 206 ++++++++++++++++++++
 tb/tb_nmr_tick_sched.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nmr_tick_sched.sv
// nmr_tick_sched: programmable timing-clock controller for the NMR pulse sequencer.
// The block samples the asynchronous 5 MHz reference and counts its rising edges.
// It generates the square wave clk_out with a one-cycle tick at each rising edge.
// It sequences IDLE -> ARM -> RUN -> (DRAIN) -> IDLE, supports an optional burst
// length, and never cuts a high phase short.
// Default active config (half_div=250, free-run) gives 10 kHz from the 5 MHz reference.
//
// Optional feature macro: NMR_TICK_SHADOW_CFG_EN
//   defined   : a shadow register accepts config during RUN/DRAIN and applies it at the
//               next falling edge of clk_out (period boundary), clearing cycle_cnt.
//   undefined : config is accepted only in IDLE (cfg_ready = state is IDLE).
//
// Ports:
//   clk_sys        system clock (all logic in this domain)
//   rst_n          synchronous active-low reset
//   clk_5M         asynchronous 5 MHz reference, sampled only
//   cfg_half_div   reference edges per half period (0 behaves as 1)
//   cfg_burst_len  periods to run, 0 = free-run
//   cfg_valid/cfg_ready  configuration handshake
//   start/stop     level-sampled run control
//   clk_out        generated timing clock
//   tick           one-cycle pulse with every clk_out rising edge
//   busy           high in ARM, RUN and DRAIN
//   done           one-cycle pulse on return to IDLE from RUN/DRAIN
//   cycle_cnt      periods started since the last start (saturating)
module nmr_tick_sched #(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             clk_5M,
    input  logic [DIV_W-1:0] cfg_half_div,
    input  logic [CNT_W-1:0] cfg_burst_len,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             start,
    input  logic             stop,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int unsigned DEF_HALF_DIV = 250;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t           state;
    logic             ref_s1;
    logic             ref_s2;
    logic             ref_en;
    logic [DIV_W-1:0] half_div_q;
    logic [CNT_W-1:0] burst_len_q;
    logic [DIV_W-1:0] edge_cnt;
    logic [DIV_W-1:0] half_div_eff;
    logic             edge_hit;
    logic             burst_end;
    logic             cfg_xfer;
    logic [CNT_W-1:0] cycle_inc;

`ifdef NMR_TICK_SHADOW_CFG_EN
    logic             shad_vld;
    logic [DIV_W-1:0] shad_half_div;
    logic [CNT_W-1:0] shad_burst_len;
    localparam logic  RUN_READY = 1'b1;
`else
    localparam logic  RUN_READY = 1'b0;
`endif

    // Rising-edge detect on the synchronized reference
    assign ref_en       = ref_s1 & ~ref_s2;
    assign half_div_eff = (half_div_q == '0) ? DIV_W'(1) : half_div_q;
    assign edge_hit     = (edge_cnt == half_div_eff);
    assign burst_end    = (burst_len_q != '0) && (cycle_cnt == burst_len_q);
    assign cfg_xfer     = cfg_valid & cfg_ready;
    assign cycle_inc    = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_W'(1);

    // Sequencer, divider and registered outputs
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ref_s1      <= 1'b0;
            ref_s2      <= 1'b0;
            half_div_q  <= DIV_W'(DEF_HALF_DIV);
            burst_len_q <= '0;
            edge_cnt    <= '0;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cycle_cnt   <= '0;
            cfg_ready   <= 1'b1;
`ifdef NMR_TICK_SHADOW_CFG_EN
            shad_vld       <= 1'b0;
            shad_half_div  <= '0;
            shad_burst_len <= '0;
`endif
        end else begin
            ref_s1 <= clk_5M;
            ref_s2 <= ref_s1;
            tick   <= 1'b0;
            done   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    clk_out <= 1'b0;
`ifdef NMR_TICK_SHADOW_CFG_EN
                    // A shadow accepted on the way back to IDLE lands here
                    if (shad_vld) begin
                        half_div_q  <= shad_half_div;
                        burst_len_q <= shad_burst_len;
                        shad_vld    <= 1'b0;
                    end
`endif
                    if (cfg_xfer) begin
                        half_div_q  <= cfg_half_div;
                        burst_len_q <= cfg_burst_len;
                    end
                    // stop wins over a simultaneous start
                    if (start && !stop) begin
                        state     <= ST_ARM;
                        busy      <= 1'b1;
                        cycle_cnt <= '0;
                        cfg_ready <= 1'b0;
                    end
                end

                ST_ARM: begin
                    if (stop) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                    end else if (ref_en) begin
                        state     <= ST_RUN;
                        edge_cnt  <= DIV_W'(1);
                        clk_out   <= 1'b0;
                        cfg_ready <= RUN_READY;
                    end
                end

                ST_RUN, ST_DRAIN: begin
`ifdef NMR_TICK_SHADOW_CFG_EN
                    if (cfg_xfer) begin
                        shad_vld       <= 1'b1;
                        shad_half_div  <= cfg_half_div;
                        shad_burst_len <= cfg_burst_len;
                        cfg_ready      <= 1'b0;
                    end
`endif
                    if (state == ST_DRAIN && !clk_out) begin
                        // Low phase: nothing to finish, leave immediately
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cfg_ready <= 1'b1;
                    end else begin
                        // Later assignments below override this when a period ends
                        if (state == ST_RUN && stop) begin
                            state <= ST_DRAIN;
                        end
                        if (ref_en) begin
                            if (edge_hit) begin
                                edge_cnt <= DIV_W'(1);
                                clk_out  <= ~clk_out;
                                if (!clk_out) begin
                                    tick      <= 1'b1;
                                    cycle_cnt <= cycle_inc;
                                end else if (burst_end || state == ST_DRAIN) begin
                                    state     <= ST_IDLE;
                                    busy      <= 1'b0;
                                    done      <= 1'b1;
                                    cfg_ready <= 1'b1;
                                end else begin
`ifdef NMR_TICK_SHADOW_CFG_EN
                                    // Period boundary: adopt the pending config
                                    if (shad_vld) begin
                                        half_div_q  <= shad_half_div;
                                        burst_len_q <= shad_burst_len;
                                        cycle_cnt   <= '0;
                                        shad_vld    <= 1'b0;
                                        cfg_ready   <= 1'b1;
                                    end
`endif
                                end
                            end else begin
                                edge_cnt <= edge_cnt + DIV_W'(1);
                            end
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nmr_tick_sched.sv
// Directed bench for nmr_tick_sched. clk_sys runs at 100 MHz and the reference at
// exactly 5 MHz, so one reference edge is 20 system cycles. Each clk_out half period
// is therefore exactly 20*half_div cycles.
module tb_nmr_tick_sched;

    localparam int unsigned DIV_W = 16;
    localparam int unsigned CNT_W = 16;

    logic             clk_sys;
    logic             rst_n;
    logic             clk_5M;
    logic [DIV_W-1:0] cfg_half_div;
    logic [CNT_W-1:0] cfg_burst_len;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             start;
    logic             stop;
    logic             clk_out;
    logic             tick;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cycle_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int tick_cnt = 0;
    int done_cnt = 0;

    nmr_tick_sched #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk_sys      (clk_sys),
        .rst_n        (rst_n),
        .clk_5M       (clk_5M),
        .cfg_half_div (cfg_half_div),
        .cfg_burst_len(cfg_burst_len),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .start        (start),
        .stop         (stop),
        .clk_out      (clk_out),
        .tick         (tick),
        .busy         (busy),
        .done         (done),
        .cycle_cnt    (cycle_cnt)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // Reference edges offset from clk_sys edges
    initial begin
        clk_5M = 1'b0;
        #3;
        forever #100 clk_5M = ~clk_5M;
    end

    always @(negedge clk_sys) begin
        if (tick === 1'b1) tick_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic wait_out(input logic lvl, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (clk_out !== lvl && n < budget);
        if (clk_out !== lvl) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_clk_out_%b: timeout after %0d cycles, clk_out=%b", lvl, n, clk_out);
        end
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (done !== 1'b1 && n < budget);
        if (done !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_done: timeout after %0d cycles", n);
        end
    endtask

    task automatic load_cfg(input logic [DIV_W-1:0] hd, input logic [CNT_W-1:0] bl);
        cfg_half_div  = hd;
        cfg_burst_len = bl;
        cfg_valid     = 1'b1;
        cyc(1);
        cfg_valid     = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
        cfg_half_div = '0; cfg_burst_len = '0;
        cyc(3);
        n_tests++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL reset_clk_out: got %b want 0", clk_out); end
        n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", tick); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cycle_cnt: got %0d want 0", cycle_cnt); end
        n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
        rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic test_default_run();
        int n;
        int t0;
        int d0;
        pulse_start();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL def_busy_arm: got %b want 1", busy); end
        wait_out(1'b1, 6000, n);
        n_tests++; if (tick !== 1'b1) begin n_fail++; $display("FAIL def_tick_at_rise: got %b want 1", tick); end
        n_tests++; if (cycle_cnt !== 16'd1) begin n_fail++; $display("FAIL def_cycle_cnt1: got %0d want 1", cycle_cnt); end
        wait_out(1'b0, 6000, n);
        t0 = tick_cnt;
        d0 = done_cnt;
        n_tests++; if (n !== 5000) begin n_fail++; $display("FAIL def_high_len: got %0d want 5000", n); end
        wait_out(1'b1, 6000, n);
        n_tests++; if (n !== 5000) begin n_fail++; $display("FAIL def_low_len: got %0d want 5000", n); end
        n_tests++; if (cycle_cnt !== 16'd2) begin n_fail++; $display("FAIL def_cycle_cnt2: got %0d want 2", cycle_cnt); end
        n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL def_busy_done: got %b/%b want 1/0", busy, done); end
`ifdef NMR_TICK_SHADOW_CFG_EN
        n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL def_cfg_ready_run: got %b want 1", cfg_ready); end
`else
        n_tests++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL def_cfg_ready_run: got %b want 0", cfg_ready); end
`endif
        cyc(1);
        n_tests++; if (tick_cnt - t0 !== 1) begin n_fail++; $display("FAIL def_ticks_per_period: got %0d want 1", tick_cnt - t0); end
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        wait_done(6000, n);
        n_tests++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL def_stop_clk_out: got %b want 0", clk_out); end
        cyc(2);
        n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL def_done_count: got %0d want 1", done_cnt - d0); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL def_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_burst();
        int n;
        int t0;
        int d0;
        load_cfg(16'd2, 16'd3);
        t0 = tick_cnt;
        d0 = done_cnt;
        pulse_start();
        wait_out(1'b1, 200, n);
        wait_out(1'b0, 200, n);
        n_tests++; if (n !== 40) begin n_fail++; $display("FAIL burst_high_len: got %0d want 40", n); end
        wait_out(1'b1, 200, n);
        n_tests++; if (n !== 40) begin n_fail++; $display("FAIL burst_low_len: got %0d want 40", n); end
        wait_done(400, n);
        n_tests++; if (clk_out !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL burst_end_state: clk_out/busy got %b/%b want 0/0", clk_out, busy); end
        n_tests++; if (cycle_cnt !== 16'd3) begin n_fail++; $display("FAIL burst_cycle_cnt: got %0d want 3", cycle_cnt); end
        cyc(2);
        n_tests++; if (tick_cnt - t0 !== 3) begin n_fail++; $display("FAIL burst_ticks: got %0d want 3", tick_cnt - t0); end
        n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL burst_done_pulses: got %0d want 1", done_cnt - d0); end
        n_tests++; if (cycle_cnt !== 16'd3) begin n_fail++; $display("FAIL burst_cycle_cnt_hold: got %0d want 3", cycle_cnt); end
    endtask

    task automatic test_div_zero();
        int n;
        load_cfg(16'd0, 16'd0);
        pulse_start();
        wait_out(1'b1, 100, n);
        wait_out(1'b0, 100, n);
        n_tests++; if (n !== 20) begin n_fail++; $display("FAIL div0_high_len: got %0d want 20", n); end
        wait_out(1'b1, 100, n);
        n_tests++; if (n !== 20) begin n_fail++; $display("FAIL div0_low_len: got %0d want 20", n); end
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        wait_done(100, n);
        cyc(2);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL div0_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_stop_high();
        int n;
        int t0;
        int d0;
        load_cfg(16'd10, 16'd0);
        t0 = tick_cnt;
        d0 = done_cnt;
        pulse_start();
        wait_out(1'b1, 400, n);
        cyc(5);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        wait_out(1'b0, 400, n);
        n_tests++; if (n + 6 !== 200) begin n_fail++; $display("FAIL stophi_high_len: got %0d want 200", n + 6); end
        n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL stophi_done_at_fall: done/busy got %b/%b want 1/0", done, busy); end
        cyc(2);
        n_tests++; if (tick_cnt - t0 !== 1) begin n_fail++; $display("FAIL stophi_ticks: got %0d want 1", tick_cnt - t0); end
        n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL stophi_done_pulses: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_stop_low();
        int n;
        int t0;
        pulse_start();
        wait_out(1'b1, 400, n);
        wait_out(1'b0, 400, n);
        t0 = tick_cnt;
        cyc(3);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL stoplo_drain: busy/done got %b/%b want 1/0", busy, done); end
        cyc(1);
        n_tests++; if (done !== 1'b1 || busy !== 1'b0 || clk_out !== 1'b0) begin n_fail++; $display("FAIL stoplo_idle: done/busy/clk_out got %b/%b/%b want 1/0/0", done, busy, clk_out); end
        cyc(30);
        n_tests++; if (tick_cnt !== t0 || clk_out !== 1'b0) begin n_fail++; $display("FAIL stoplo_no_tick: extra ticks %0d clk_out %b want 0/0", tick_cnt - t0, clk_out); end
    endtask

    task automatic test_start_stop_together();
        start = 1'b1;
        stop  = 1'b1;
        cyc(1);
        start = 1'b0;
        stop  = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ss_busy: got %b want 0", busy); end
        cyc(40);
        n_tests++; if (clk_out !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL ss_idle: clk_out/busy/cfg_ready got %b/%b/%b want 0/0/1", clk_out, busy, cfg_ready); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        int d0;
        pulse_start();
        wait_out(1'b1, 400, n);
        cyc(3);
        n_tests++; if (cycle_cnt !== 16'd1) begin n_fail++; $display("FAIL rst_pre_cycle_cnt: got %0d want 1", cycle_cnt); end
        d0 = done_cnt;
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        n_tests++; if (clk_out !== 1'b0 || cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_mid_state: clk_out/cycle_cnt got %b/%0d want 0/0", clk_out, cycle_cnt); end
        n_tests++; if (busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_flags: busy/done/cfg_ready got %b/%b/%b want 0/0/1", busy, done, cfg_ready); end
        cyc(300);
        n_tests++; if (done_cnt !== d0 || clk_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_done: done pulses %0d clk_out %b want 0/0", done_cnt - d0, clk_out); end
    endtask

    task automatic test_cfg_during_run();
        int n;
        load_cfg(16'd4, 16'd0);
        pulse_start();
        wait_out(1'b1, 200, n);
`ifdef NMR_TICK_SHADOW_CFG_EN
        n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL shd_ready_empty: got %b want 1", cfg_ready); end
`else
        n_tests++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL run_ready_locked: got %b want 0", cfg_ready); end
`endif
        cfg_half_div  = 16'd8;
        cfg_burst_len = 16'd0;
        cfg_valid     = 1'b1;
        cyc(1);
        cfg_valid     = 1'b0;
        n_tests++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL cfg_ready_after_offer: got %b want 0", cfg_ready); end
        wait_out(1'b0, 200, n);
        n_tests++; if (n + 1 !== 80) begin n_fail++; $display("FAIL cfg_old_high_len: got %0d want 80", n + 1); end
`ifdef NMR_TICK_SHADOW_CFG_EN
        n_tests++; if (cfg_ready !== 1'b1 || cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL shd_applied: cfg_ready/cycle_cnt got %b/%0d want 1/0", cfg_ready, cycle_cnt); end
        wait_out(1'b1, 400, n);
        n_tests++; if (n !== 160) begin n_fail++; $display("FAIL shd_new_low_len: got %0d want 160", n); end
        n_tests++; if (cycle_cnt !== 16'd1) begin n_fail++; $display("FAIL shd_cycle_cnt: got %0d want 1", cycle_cnt); end
        wait_out(1'b0, 400, n);
        n_tests++; if (n !== 160) begin n_fail++; $display("FAIL shd_new_high_len: got %0d want 160", n); end
`else
        n_tests++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL run_ready_at_fall: got %b want 0", cfg_ready); end
        wait_out(1'b1, 400, n);
        n_tests++; if (n !== 80) begin n_fail++; $display("FAIL run_low_len_unchanged: got %0d want 80", n); end
        n_tests++; if (cycle_cnt !== 16'd2) begin n_fail++; $display("FAIL run_cycle_cnt: got %0d want 2", cycle_cnt); end
`endif
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        wait_done(400, n);
        cyc(2);
        n_tests++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL cfg_end_idle: busy/cfg_ready got %b/%b want 0/1", busy, cfg_ready); end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_burst();
        test_div_zero();
        test_stop_high();
        test_stop_low();
        test_start_stop_together();
        test_reset_mid_run();
        test_cfg_during_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
